// File: rtl/spectral_flux_acc_if.sv
// Magnitude-squared beat stream into the flux stage, plus the flux result and error pulses back out.
// Upstream owns the mag_* signals; the flux stage owns flux, flux_valid and frame_err.
interface spectral_flux_acc_if #(
   parameter int W      = 16,
   parameter int FLUX_W = 48
);
   logic              mag_valid;
   logic [2*W:0]      mag_sq;
   logic              mag_sop;
   logic [FLUX_W-1:0] flux;
   logic              flux_valid;
   logic              frame_err;

   modport master (
      output mag_valid, mag_sq, mag_sop,
      input  flux, flux_valid, frame_err
   );

   modport slave (
      input  mag_valid, mag_sq, mag_sop,
      output flux, flux_valid, frame_err
   );
endinterface

// File: rtl/spectral_flux_acc.sv
// Per-frame spectral flux: sum of positive bin increases against the previous frame, held in a local RAM.
// Latency: flux_valid 3 cycles after the last used bin; no backpressure, accepts one beat per cycle.
module spectral_flux_acc #(
   parameter int W         = 16,
   parameter int NFFT      = 256,
   parameter int BINS_USED = 128,
   parameter int FLUX_W    = 48
) (
   input  logic                clk,
   input  logic                reset,
   spectral_flux_acc_if.slave  io_mag
);
   localparam int MW = 2*W + 1;
   localparam int DW = 2*W + 2;
   localparam int SW = FLUX_W + 1;
   localparam int CW = (NFFT > 1) ? $clog2(NFFT) : 1;
   localparam int AW = (BINS_USED > 1) ? $clog2(BINS_USED) : 1;

   if ((NFFT & (NFFT - 1)) != 0) begin : g_bad_nfft
      $error("spectral_flux_acc: NFFT must be a power of two");
   end
   if (BINS_USED > NFFT || BINS_USED < 1) begin : g_bad_bins
      $error("spectral_flux_acc: BINS_USED must be in 1..NFFT");
   end
   if (FLUX_W < MW + AW) begin : g_bad_fluxw
      $error("spectral_flux_acc: FLUX_W too narrow for BINS_USED bins");
   end

   logic [CW-1:0]        r_bin_cnt;
   logic                 w_sop;
   logic                 w_resync;
   logic [CW-1:0]        w_bin;
   logic                 w_used;
   logic [AW-1:0]        w_addr;

   logic [MW-1:0]        r_prev_mem [BINS_USED];
   logic [MW-1:0]        r_prev_rd;

   logic                 r_s1_vld;
   logic [MW-1:0]        r_s1_cur;
   logic                 r_s1_first;
   logic                 r_s1_last;

   logic signed [DW-1:0] w_diff;
   logic [MW-1:0]        w_contrib;
   logic [SW-1:0]        w_sum;
   logic [FLUX_W-1:0]    w_acc_nxt;
   logic [FLUX_W-1:0]    r_acc;
   logic                 r_primed;
   logic                 r_s2_emit;

   logic [FLUX_W-1:0]    r_flux;
   logic                 r_flux_vld;
   logic                 r_frame_err;

   // A sop beat always restarts framing at bin 0, whatever the counter says.
   always_comb begin
      w_sop    = io_mag.mag_valid & io_mag.mag_sop;
      w_resync = w_sop & (r_bin_cnt != '0);
      w_bin    = w_sop ? '0 : r_bin_cnt;
      w_used   = io_mag.mag_valid && (int'(w_bin) < BINS_USED);
      w_addr   = w_bin[AW-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_bin_cnt   <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= w_resync;
         if (io_mag.mag_valid) begin
            r_bin_cnt <= w_bin + 1'b1;
         end
      end
   end

   // Read and write share the address; the read returns the value before this beat's write.
   always_ff @(posedge clk) begin
      if (w_used) begin
         r_prev_rd          <= r_prev_mem[w_addr];
         r_prev_mem[w_addr] <= io_mag.mag_sq;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_vld   <= 1'b0;
         r_s1_cur   <= '0;
         r_s1_first <= 1'b0;
         r_s1_last  <= 1'b0;
      end else begin
         r_s1_vld <= w_used;
         if (w_used) begin
            r_s1_cur   <= io_mag.mag_sq;
            r_s1_first <= (w_bin == '0);
            r_s1_last  <= (int'(w_bin) == BINS_USED - 1);
         end
      end
   end

   always_comb begin
      w_diff    = signed'({1'b0, r_s1_cur}) - signed'({1'b0, r_prev_rd});
      w_contrib = (r_primed && (w_diff > 0)) ? w_diff[MW-1:0] : '0;
      w_sum     = {1'b0, r_acc} + SW'(w_contrib);
      if (r_s1_first) begin
         w_acc_nxt = FLUX_W'(w_contrib);
      end else if (w_sum[FLUX_W]) begin
         w_acc_nxt = '1;
      end else begin
         w_acc_nxt = w_sum[FLUX_W-1:0];
      end
   end

   // primed flips as the priming frame's last bin leaves stage 2, so a following
   // frame's bin 0 one cycle behind it already sees the RAM as valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc     <= '0;
         r_primed  <= 1'b0;
         r_s2_emit <= 1'b0;
      end else begin
         r_s2_emit <= r_s1_vld & r_s1_last & r_primed;
         if (r_s1_vld) begin
            r_acc <= w_acc_nxt;
            if (r_s1_last) begin
               r_primed <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_flux     <= '0;
         r_flux_vld <= 1'b0;
      end else begin
         r_flux_vld <= r_s2_emit;
         if (r_s2_emit) begin
            r_flux <= r_acc;
         end
      end
   end

   assign io_mag.flux       = r_flux;
   assign io_mag.flux_valid = r_flux_vld;
   assign io_mag.frame_err  = r_frame_err;
endmodule

// File: doc/spectral_flux_acc.md
Name: spectral_flux_acc

Overview:
- Consumer of the FFT magnitude-squared stream: takes one registered mag_sq beat per FFT bin and computes per-frame spectral flux, i.e. the sum over the used bins of max(0, cur[k] − prev[k]).
- Holds the previous frame's magnitudes in an internal RAM.
- Emits one flux value per frame to the onset/BPM detection stage.
- Sits directly downstream of the magnitude-squared stage and has no backpressure; beats may arrive back-to-back.

Parameters:
- W, 16: FFT component width; the magnitude input is 2W+1 bits.
- NFFT, 256: beats per frame; must be a power of two.
- BINS_USED, 128: bins 0..BINS_USED-1 contribute to flux; the remaining beats are counted, then ignored. BINS_USED ≤ NFFT.
- FLUX_W, 48: accumulator and output width; must satisfy FLUX_W ≥ 2W+1+log2(BINS_USED).

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high.
- mag_valid, input, 1: mag_sq carries a valid bin this cycle.
- mag_sq, input, 2W+1: unsigned magnitude squared.
- mag_sop, input, 1: first bin of a frame, qualified by mag_valid. May be tied low, in which case framing uses the counter only.
- flux, output, FLUX_W: flux of the last completed frame; held between updates.
- flux_valid, output, 1: one-cycle pulse when flux updates.
- frame_err, output, 1: one-cycle pulse when mag_sop arrives mid-frame.

Behaviour:
- Reset values:
  - flux = 0, flux_valid = 0, frame_err = 0.
  - Bin counter = 0, accumulator = 0, primed = 0.
  - Pipeline valids = 0.
  - The prev RAM is not cleared.
- Bin counter:
  - Increments on each mag_valid beat.
  - Wraps from NFFT-1 to 0.
  - The beat's bin index is the counter value before the increment.
- Resync on mag_sop:
  - If mag_valid & mag_sop and counter ≠ 0: frame_err pulses the next cycle. This beat is treated as bin 0, the counter becomes 1, and the accumulator is cleared by this beat.
  - The partial frame produces no flux_valid. primed is unchanged.
  - mag_sop with counter = 0 is normal and raises no error.
- Stage 1 (cycle of the beat), for bin < BINS_USED:
  - Issue a synchronous read of prev[bin].
  - In the same cycle, write mag_sq to prev[bin]. The RAM must return old data on read-during-write.
  - Register mag_sq, bin, a "last" flag (bin == BINS_USED-1) and a "first" flag (bin == 0).
- Bins ≥ BINS_USED: counter only; no RAM access and no accumulation.
- Stage 2 (beat + 1):
  - diff = cur − prev, computed at 2W+2 bits signed.
  - contrib = diff > 0 ? diff : 0. If primed = 0, contrib = 0.
  - If "first": acc <= contrib; otherwise acc <= acc + contrib.
  - acc saturates at 2^FLUX_W − 1.
- Stage 3 (beat + 2), on "last":
  - If primed = 1: flux <= updated acc and flux_valid pulses. Latency is 3 cycles from the bin BINS_USED-1 beat to flux_valid high.
  - If primed = 0: no flux_valid; primed <= 1.
- Priming: the first complete frame after reset only loads the prev RAM.
- A frame aborted by resync never sets primed.
- Back-to-back beats at full rate must be handled with no bubbles. Gaps (mag_valid low) of any length may occur mid-frame; state is held.
- Reset mid-frame: all state returns to reset values, the in-flight pipeline is discarded, and the next beat is bin 0 of a new priming frame.

Test Plan:
- Priming (NFFT=8, BINS_USED=4): frame A = {1,2,3,4,9,9,9,9} back-to-back → no flux_valid, frame_err stays 0.
- Constant: after A, send A again → flux_valid 3 cycles after the bin-3 beat, flux = 0.
- Increase: after A, send {5,2,1,10,0,0,0,0} → flux = 4+0+0+6 = 10; mirror bins 4..7 do not affect the result.
- Gaps: repeat the increase test with mag_valid low for 3 cycles between every beat → identical flux = 10. flux stays at 10 until the next frame completes.
- Mid-frame sop: 3 beats, then mag_sop on a beat → frame_err pulse, no flux_valid for the aborted frame. The following full frame is timed from the sop beat, with its flux computed against the RAM contents.
- Reset mid-frame: after priming, assert reset at bin 2, then send two full frames {1,1,1,1,…} and {3,3,3,3,…} → the first frame gives no flux_valid, the second gives flux = 8.
